// File: rtl/poly_oscillator.sv
// Time-multiplexed polyphonic oscillator. One shared phase accumulator and waveform
// datapath is swept across per-voice register sets once per sample tick.
module poly_oscillator #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_VOICES = 8,
    parameter int LUT_AW     = 10,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_in,
    input  logic                  cfg_we,
    input  logic [VW-1:0]         cfg_voice,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_data,
    output logic                  out_valid,
    output logic [VW-1:0]         out_voice,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);
    localparam int              DW        = DATA_WIDTH;
    localparam int              LUT_N     = 1 << LUT_AW;
    localparam logic [DW-1:0]   MAX_V     = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   MIN_V     = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]   NEG_MAX_V = {1'b1, {(DW-2){1'b0}}, 1'b1};
    localparam logic [LUT_AW:0] LUT_TOP   = {1'b1, {LUT_AW{1'b0}}};
    localparam logic [VW-1:0]   LAST_V    = VW'(NUM_VOICES - 1);
    localparam real             HALF_PI   = 1.5707963267948966;
    localparam real             MAX_R     = (2.0 ** (DW - 1)) - 1.0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [VW-1:0]       idx_r;
    logic [31:0]         phase_r  [NUM_VOICES];
    logic [31:0]         incr_r   [NUM_VOICES];
    logic [31:0]         pw_r     [NUM_VOICES];
    logic [1:0]          active_r [NUM_VOICES];
    logic [1:0]          pend_r   [NUM_VOICES];
    logic [DW-1:0]       sine_lut_s [LUT_N+1];

    logic                issue_s;
    logic                start_s;
    logic                ovr_set_s;
    logic                ovr_clr_s;
    logic                cfg_ok_s;
    logic [NUM_VOICES-1:0] wr_sel_s;
    logic [NUM_VOICES-1:0] prst_s;
    logic [NUM_VOICES-1:0] iss_s;
    logic [31:0]         ph_s;
    logic [32:0]         sum_s;
    logic [LUT_AW:0]     lut_i_s;
    logic [LUT_AW:0]     lut_idx_s;
    logic [DW-1:0]       lut_val_s;
    logic [DW-1:0]       tri_s;
    logic [DW-1:0]       sample_s;

    // Quarter-wave sine table, rounded at elaboration; the last entry is pinned to full scale.
    for (genvar j = 0; j <= LUT_N; j++) begin : g_lut
        localparam int LV = $rtoi(MAX_R * $sin(HALF_PI * j / LUT_N) + 0.5);
        assign sine_lut_s[j] = (j == LUT_N) ? MAX_V : LV[DW-1:0];
    end

    // Config decode and per-voice event strobes.
    always_comb begin
        cfg_ok_s  = cfg_we && (int'(cfg_voice) < NUM_VOICES);
        ovr_clr_s = cfg_ok_s && (cfg_addr == 2'd3) && cfg_data[1];
        wr_sel_s  = '0;
        prst_s    = '0;
        iss_s     = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            wr_sel_s[v] = cfg_ok_s && (int'(cfg_voice) == v);
            prst_s[v]   = wr_sel_s[v] && (cfg_addr == 2'd3) && cfg_data[0];
            iss_s[v]    = issue_s && (int'(idx_r) == v);
        end
    end

    // Shared datapath: sample from the pre-increment phase of the voice being issued.
    always_comb begin
        ph_s      = phase_r[idx_r];
        sum_s     = {1'b0, ph_s} + {1'b0, incr_r[idx_r]};
        lut_i_s   = {1'b0, ph_s[29 -: LUT_AW]};
        lut_idx_s = ph_s[30] ? (LUT_TOP - lut_i_s) : lut_i_s;
        lut_val_s = sine_lut_s[lut_idx_s];
        tri_s     = ph_s[31] ? ~ph_s[30 -: DW] : ph_s[30 -: DW];
        case (active_r[idx_r])
            2'b00:   sample_s = ph_s[31] ? -lut_val_s : lut_val_s;
            2'b01:   sample_s = (ph_s < pw_r[idx_r]) ? MAX_V : NEG_MAX_V;
            2'b10:   sample_s = ph_s[31 -: DW] ^ MIN_V;
            2'b11:   sample_s = tri_s ^ MIN_V;
            default: sample_s = '0;
        endcase
    end

    // Per-voice registers; a phase reset beats the accumulator update in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_r[v]  <= 32'h0000_0000;
                incr_r[v]   <= 32'h0000_0000;
                pw_r[v]     <= 32'h8000_0000;
                active_r[v] <= 2'b00;
                pend_r[v]   <= 2'b00;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_sel_s[v] && (cfg_addr == 2'd0)) incr_r[v] <= cfg_data;
                if (wr_sel_s[v] && (cfg_addr == 2'd1)) pend_r[v] <= cfg_data[1:0];
                if (wr_sel_s[v] && (cfg_addr == 2'd2)) pw_r[v]   <= cfg_data;
                if (prst_s[v]) begin
                    phase_r[v]  <= 32'h0000_0000;
                    active_r[v] <= pend_r[v];
                end else if (iss_s[v]) begin
                    phase_r[v] <= sum_s[31:0];
                    if (sum_s[32]) active_r[v] <= pend_r[v];
                end
            end
        end
    end

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Sweep FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = step_in ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nx_s = (idx_r == LAST_V) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Sweep FSM decoded controls; a tick in DRAIN still counts as arriving while busy.
    always_comb begin
        issue_s   = (state_r == ST_RUN);
        start_s   = (state_r == ST_IDLE) && step_in;
        ovr_set_s = (state_r != ST_IDLE) && step_in;
    end

    // Voice index and registered output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= '0;
            out_valid <= 1'b0;
            out_voice <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            idx_r     <= start_s ? '0 : (issue_s ? idx_r + 1'b1 : idx_r);
            out_valid <= issue_s;
            out_voice <= issue_s ? idx_r : '0;
            out_data  <= issue_s ? sample_s : '0;
            out_last  <= issue_s && (idx_r == LAST_V);
            busy      <= (state_nx_s != ST_IDLE);
            overrun   <= ovr_set_s | (overrun & ~ovr_clr_s);
        end
    end

endmodule

// File: tb/tb_poly_oscillator.sv
// Bench for poly_oscillator: table of hand-derived waveform vectors, hand-written
// corner sequences and randomized sweeps checked against an arithmetic voice model.
module tb_poly_oscillator;
    localparam int DW = 24;
    localparam int NV = 8;
    localparam int VW = 3;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          step_in;
    logic          cfg_we;
    logic [VW-1:0] cfg_voice;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_data;
    logic          out_valid;
    logic [VW-1:0] out_voice;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain integers, phase kept in 0 .. 2^32-1.
    longint     m_phase [NV];
    longint     m_incr  [NV];
    longint     m_pw    [NV];
    logic [1:0] m_act   [NV];
    logic [1:0] m_pend  [NV];
    bit         m_over;
    longint     swp_got [NV];

    typedef struct {
        int          voice;
        logic [1:0]  wave;
        logic [31:0] incr;
        logic [31:0] pw;
        int          e [5];
    } vec_t;
    vec_t tbl [5];

    poly_oscillator dut (
        .clk(clk), .rst_n(rst_n), .step_in(step_in), .cfg_we(cfg_we),
        .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_voice(out_voice), .out_data(out_data),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    function automatic logic signed [63:0] sx(input logic [DW-1:0] d);
        return {{(64-DW){d[DW-1]}}, d};
    endfunction

    function automatic longint lut_ref(input int j);
        real mx;
        mx = (2.0 ** (DW - 1)) - 1.0;
        if (j == (1 << AW)) return (longint'(1) << (DW - 1)) - 1;
        return longint'($rtoi(mx * $sin(3.141592653589793 / 2.0 * j / (1 << AW)) + 0.5));
    endfunction

    function automatic longint ref_sample(input logic [1:0] w, input longint p, input longint pw);
        longint half;
        longint mx;
        longint q;
        int quad;
        int i;
        int j;
        half = longint'(1) << (DW - 1);
        mx   = half - 1;
        case (w)
            2'd0: begin
                quad = int'(p >> 30);
                i    = int'((p >> (30 - AW)) % (1 << AW));
                j    = (quad % 2 == 1) ? (1 << AW) - i : i;
                return (quad >= 2) ? -lut_ref(j) : lut_ref(j);
            end
            2'd1:    return (p < pw) ? mx : -mx;
            2'd2:    return (p >> (32 - DW)) - half;
            default: begin
                q = (p >= 64'h8000_0000) ? (64'hFFFF_FFFF - p) : p;
                return (q >> (31 - DW)) - half;
            end
        endcase
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_incr[v]  = 0;
            m_pw[v]    = 64'h8000_0000;
            m_act[v]   = 2'd0;
            m_pend[v]  = 2'd0;
        end
        m_over = 1'b0;
    endfunction

    function automatic void model_write(input int v, input int a, input logic [31:0] d);
        case (a)
            0: m_incr[v] = longint'({32'd0, d});
            1: m_pend[v] = d[1:0];
            2: m_pw[v]   = longint'({32'd0, d});
            default: begin
                if (d[0]) begin
                    m_phase[v] = 0;
                    m_act[v]   = m_pend[v];
                end
                if (d[1]) m_over = 1'b0;
            end
        endcase
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0; step_in = 1'b0; cfg_we = 1'b0;
        cfg_voice = '0; cfg_addr = 2'd0; cfg_data = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int v, input int a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = v[VW-1:0]; cfg_addr = a[1:0]; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        model_write(v, a, d);
        chk("cfg_overrun", overrun, m_over);
    endtask

    // One full sweep, checked cycle by cycle; optional extra tick / phase-reset injection.
    task automatic run_sweep(input int step_at, input int prst_v, input bit clr_with_step);
        longint expd [NV];
        bit exp_over;
        for (int v = 0; v < NV; v++) expd[v] = ref_sample(m_act[v], m_phase[v], m_pw[v]);
        exp_over = m_over || (step_at > 0);
        @(negedge clk);
        step_in = 1'b1;
        for (int j = 1; j <= NV + 2; j++) begin
            @(negedge clk);
            step_in = 1'b0;
            cfg_we  = 1'b0;
            chk($sformatf("busy_c%0d", j), busy, (j <= NV + 1));
            if (j >= 2 && j <= NV + 1) begin
                int k;
                k = j - 2;
                chk($sformatf("valid_v%0d", k), out_valid, 1);
                chk($sformatf("voice_v%0d", k), out_voice, k);
                chk($sformatf("data_v%0d", k), sx(out_data), expd[k]);
                chk($sformatf("last_v%0d", k), out_last, (k == NV - 1));
                swp_got[k] = sx(out_data);
            end else begin
                chk($sformatf("idle_valid_c%0d", j), out_valid, 0);
            end
            if (j == step_at) begin
                step_in = 1'b1;
                if (clr_with_step) begin
                    cfg_we = 1'b1; cfg_voice = '0; cfg_addr = 2'd3; cfg_data = 32'd2;
                end
            end
            if (prst_v >= 0 && j == prst_v + 1) begin
                cfg_we = 1'b1; cfg_voice = prst_v[VW-1:0]; cfg_addr = 2'd3; cfg_data = 32'd1;
            end
        end
        chk("sweep_overrun", overrun, exp_over);
        for (int v = 0; v < NV; v++) begin
            if (v == prst_v) begin
                m_phase[v] = 0;
                m_act[v]   = m_pend[v];
            end else begin
                m_phase[v] = m_phase[v] + m_incr[v];
                if (m_phase[v] >= 64'h1_0000_0000) begin
                    m_phase[v] = m_phase[v] - 64'h1_0000_0000;
                    m_act[v]   = m_pend[v];
                end
            end
        end
        m_over = exp_over;
    endtask

    initial begin
        tbl[0] = '{voice: 0, wave: 2'd2, incr: 32'h4000_0000, pw: 32'h8000_0000,
                   e: '{-8388608, -4194304, 0, 4194304, -8388608}};
        tbl[1] = '{voice: 1, wave: 2'd1, incr: 32'h4000_0000, pw: 32'h8000_0000,
                   e: '{8388607, 8388607, -8388607, -8388607, 8388607}};
        tbl[2] = '{voice: 4, wave: 2'd1, incr: 32'h4000_0000, pw: 32'h0000_0000,
                   e: '{-8388607, -8388607, -8388607, -8388607, -8388607}};
        tbl[3] = '{voice: 2, wave: 2'd0, incr: 32'h4000_0000, pw: 32'h8000_0000,
                   e: '{0, 8388607, 0, -8388607, 0}};
        tbl[4] = '{voice: 3, wave: 2'd3, incr: 32'h4000_0000, pw: 32'h8000_0000,
                   e: '{-8388608, 0, 8388607, -1, -8388608}};

        // Reset state and a sweep of silent sine voices.
        reset_dut();
        chk("rst_valid", out_valid, 0);
        chk("rst_voice", out_voice, 0);
        chk("rst_data", sx(out_data), 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        run_sweep(0, -1, 1'b0);
        for (int v = 0; v < NV; v++) chk($sformatf("silent_v%0d", v), swp_got[v], 0);

        // Table-driven waveform vectors.
        for (int t = 0; t < 5; t++) begin
            reset_dut();
            cfg_write(tbl[t].voice, 0, tbl[t].incr);
            cfg_write(tbl[t].voice, 2, tbl[t].pw);
            cfg_write(tbl[t].voice, 1, {30'd0, tbl[t].wave});
            cfg_write(tbl[t].voice, 3, 32'd1);
            for (int s = 0; s < 5; s++) begin
                run_sweep(0, -1, 1'b0);
                chk($sformatf("tbl%0d_s%0d", t, s), swp_got[tbl[t].voice], tbl[t].e[s]);
            end
        end

        // Wrap-synchronised wave switch, then a phase reset landing in the issue cycle.
        reset_dut();
        cfg_write(0, 0, 32'h4000_0000);
        cfg_write(0, 1, 32'd2);
        cfg_write(0, 3, 32'd1);
        run_sweep(0, -1, 1'b0);
        chk("sw_saw0", swp_got[0], -8388608);
        cfg_write(0, 1, 32'd1);
        run_sweep(0, -1, 1'b0);
        chk("sw_saw1", swp_got[0], -4194304);
        run_sweep(0, -1, 1'b0);
        chk("sw_saw2", swp_got[0], 0);
        run_sweep(0, -1, 1'b0);
        chk("sw_saw3", swp_got[0], 4194304);
        run_sweep(0, -1, 1'b0);
        chk("sw_sq_after_wrap", swp_got[0], 8388607);
        cfg_write(0, 1, 32'd2);
        run_sweep(0, 0, 1'b0);
        chk("prst_old_sample", swp_got[0], 8388607);
        run_sweep(0, -1, 1'b0);
        chk("prst_next_sample", swp_got[0], -8388608);
        run_sweep(0, -1, 1'b0);
        chk("prst_following", swp_got[0], -4194304);

        // Ticks while busy: mid-sweep, in DRAIN, and together with a clear.
        reset_dut();
        run_sweep(3, -1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("no_restart_valid", out_valid, 0);
            chk("no_restart_busy", busy, 0);
        end
        cfg_write(0, 3, 32'd2);
        chk("ovr_cleared", overrun, 0);
        run_sweep(NV + 1, -1, 1'b0);
        chk("ovr_drain", overrun, 1);
        cfg_write(2, 3, 32'd2);
        run_sweep(5, -1, 1'b1);
        chk("ovr_set_wins", overrun, 1);
        cfg_write(0, 3, 32'd2);

        // Reset asserted in the middle of a sweep.
        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_valid_before", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", sx(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_c%0d", c), out_valid, 0);
        end

        // Randomized configuration and sweeps against the model.
        reset_dut();
        for (int v = 0; v < NV; v++) begin
            cfg_write(v, 0, $urandom);
            cfg_write(v, 2, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            cfg_write(v, 1, $urandom);
            cfg_write(v, 3, 32'd1);
        end
        for (int s = 0; s < 30; s++) begin
            int nw;
            int pv;
            int sa;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                cfg_write($urandom_range(0, NV - 1), $urandom_range(0, 3), $urandom);
            pv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NV - 1) : -1;
            sa = ($urandom_range(0, 4) == 0) ? $urandom_range(2, NV + 1) : 0;
            run_sweep(sa, pv, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
